// File: rtl/tx_write_arbiter.sv
// rtl/tx_write_arbiter.sv - round-robin arbiter sharing the UART TX FIFO write port
// between two byte producers, each behind a one-byte holding register.
module tx_write_arbiter #(
   parameter int NB_ARB_DATA  = 8,
   parameter int NB_ARB_COUNT = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_arb_valid0,
   input  logic [NB_ARB_DATA-1:0]  i_arb_data0,
   output logic                    o_arb_ready0,
   input  logic                    i_arb_valid1,
   input  logic [NB_ARB_DATA-1:0]  i_arb_data1,
   output logic                    o_arb_ready1,
   input  logic                    i_arb_FULL,
   output logic                    o_arb_WRITE,
   output logic [NB_ARB_DATA-1:0]  o_arb_WRITEDATA,
   output logic [NB_ARB_COUNT-1:0] o_arb_COUNT
);

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'b01,
      ARB_WRITE = 2'b10
   } arb_state_t;

   arb_state_t              r_state;
   arb_state_t              w_state_next;
   logic [NB_ARB_DATA-1:0]  r_hold0;
   logic [NB_ARB_DATA-1:0]  r_hold1;
   logic                    r_hold_valid0;
   logic                    r_hold_valid1;
   logic                    r_last_grant;
   logic                    r_write;
   logic [NB_ARB_DATA-1:0]  r_writedata;
   logic [NB_ARB_COUNT-1:0] r_count;

   logic                    w_grant0;
   logic                    w_grant1;
   logic                    w_write_next;
   logic                    w_last_grant_next;
   logic [NB_ARB_DATA-1:0]  w_writedata_next;
   logic [NB_ARB_COUNT-1:0] w_count_next;
   logic                    w_accept0;
   logic                    w_accept1;

   assign o_arb_ready0    = ~r_hold_valid0;
   assign o_arb_ready1    = ~r_hold_valid1;
   assign o_arb_WRITE     = r_write;
   assign o_arb_WRITEDATA = r_writedata;
   assign o_arb_COUNT     = r_count;

   assign w_accept0 = i_arb_valid0 & ~r_hold_valid0;
   assign w_accept1 = i_arb_valid1 & ~r_hold_valid1;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next      = ARB_IDLE;
      w_write_next      = 1'b0;
      w_writedata_next  = r_writedata;
      w_count_next      = r_count;
      w_last_grant_next = r_last_grant;
      w_grant0          = 1'b0;
      w_grant1          = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (!i_arb_FULL && (r_hold_valid0 || r_hold_valid1)) begin
               // On a tie the requester that did not win last time goes first
               if (r_hold_valid0 && (!r_hold_valid1 || r_last_grant)) begin
                  w_grant0          = 1'b1;
                  w_writedata_next  = r_hold0;
                  w_last_grant_next = 1'b0;
               end else begin
                  w_grant1          = 1'b1;
                  w_writedata_next  = r_hold1;
                  w_last_grant_next = 1'b1;
               end
               w_write_next = 1'b1;
               w_count_next = r_count + NB_ARB_COUNT'(1);
               w_state_next = ARB_WRITE;
            end
         end
         ARB_WRITE: begin
            w_state_next = ARB_IDLE;
         end
         default: begin
            w_state_next = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_hold0       <= '0;
         r_hold1       <= '0;
         r_hold_valid0 <= 1'b0;
         r_hold_valid1 <= 1'b0;
         r_last_grant  <= 1'b1;
         r_write       <= 1'b0;
         r_writedata   <= '0;
         r_count       <= '0;
      end else begin
         if (w_grant0) begin
            r_hold_valid0 <= 1'b0;
         end else if (w_accept0) begin
            r_hold0       <= i_arb_data0;
            r_hold_valid0 <= 1'b1;
         end
         if (w_grant1) begin
            r_hold_valid1 <= 1'b0;
         end else if (w_accept1) begin
            r_hold1       <= i_arb_data1;
            r_hold_valid1 <= 1'b1;
         end
         r_last_grant <= w_last_grant_next;
         r_write      <= w_write_next;
         r_writedata  <= w_writedata_next;
         r_count      <= w_count_next;
      end
   end

endmodule

// File: tb/tb_tx_write_arbiter.sv
// tb/tb_tx_write_arbiter.sv - directed self-checking bench for tx_write_arbiter.
module tb_tx_write_arbiter;

   logic       clk;
   logic       reset;
   logic       v0;
   logic [7:0] d0;
   logic       v1;
   logic [7:0] d1;
   logic       full;
   logic       r0;
   logic       r1;
   logic       wr;
   logic [7:0] wd;
   logic [15:0] cnt;
   logic       s_r0;
   logic       s_r1;
   logic       s_wr;
   logic [7:0] s_wd;
   logic [2:0] s_cnt;

   int checks;
   int errors;

   tx_write_arbiter #(.NB_ARB_DATA(8), .NB_ARB_COUNT(16)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_arb_valid0(v0), .i_arb_data0(d0), .o_arb_ready0(r0),
      .i_arb_valid1(v1), .i_arb_data1(d1), .o_arb_ready1(r1),
      .i_arb_FULL(full), .o_arb_WRITE(wr), .o_arb_WRITEDATA(wd), .o_arb_COUNT(cnt)
   );

   // Narrow-counter copy on the same stimulus, so the wrap is reached quickly
   tx_write_arbiter #(.NB_ARB_DATA(8), .NB_ARB_COUNT(3)) dut_small (
      .i_clk(clk), .i_reset(reset),
      .i_arb_valid0(v0), .i_arb_data0(d0), .o_arb_ready0(s_r0),
      .i_arb_valid1(v1), .i_arb_data1(d1), .o_arb_ready1(s_r1),
      .i_arb_FULL(full), .o_arb_WRITE(s_wr), .o_arb_WRITEDATA(s_wd), .o_arb_COUNT(s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00; full = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_write got %0b exp 0", wr); end
      checks++; if (wd !== 8'h00) begin errors++; $display("FAIL reset_writedata got %h exp 00", wd); end
      checks++; if (cnt !== 16'h0000) begin errors++; $display("FAIL reset_count got %h exp 0000", cnt); end
      checks++; if (r0 !== 1'b1 || r1 !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b%0b exp 11", r0, r1); end
   endtask

   task automatic test_single();
      do_reset();
      v0 = 1'b1; d0 = 8'h3C;
      tick();
      v0 = 1'b0; d0 = 8'h00;
      checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL single_ready_low got %0b exp 0", r0); end
      checks++; if (wr !== 1'b0) begin errors++; $display("FAIL single_no_early_write got %0b exp 0", wr); end
      tick();
      checks++; if (wr !== 1'b1 || wd !== 8'h3C) begin errors++; $display("FAIL single_write got %0b/%h exp 1/3c", wr, wd); end
      checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL single_count got %0d exp 1", cnt); end
      checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL single_ready_back got %0b exp 1", r0); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (wr !== 1'b0) begin errors++; $display("FAIL single_no_dup cycle %0d got %0b exp 0", i, wr); end
      end
      checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL single_count_final got %0d exp 1", cnt); end
   endtask

   task automatic test_tie();
      do_reset();
      v0 = 1'b1; d0 = 8'hAA; v1 = 1'b1; d1 = 8'h55;
      tick();
      v0 = 1'b0; v1 = 1'b0;
      checks++; if (r0 !== 1'b0 || r1 !== 1'b0) begin errors++; $display("FAIL tie_ready got %0b%0b exp 00", r0, r1); end
      tick();
      checks++; if (wr !== 1'b1 || wd !== 8'hAA) begin errors++; $display("FAIL tie_first got %0b/%h exp 1/aa", wr, wd); end
      tick();
      checks++; if (wr !== 1'b0) begin errors++; $display("FAIL tie_gap got %0b exp 0", wr); end
      tick();
      checks++; if (wr !== 1'b1 || wd !== 8'h55) begin errors++; $display("FAIL tie_second got %0b/%h exp 1/55", wr, wd); end
      checks++; if (cnt !== 16'd2) begin errors++; $display("FAIL tie_count got %0d exp 2", cnt); end
      checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL tie_ready1_back got %0b exp 1", r1); end
   endtask

   task automatic test_backpressure();
      do_reset();
      full = 1'b1;
      v0 = 1'b1; d0 = 8'h11; v1 = 1'b1; d1 = 8'h22;
      tick();
      v0 = 1'b0; v1 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++; if (wr !== 1'b0) begin errors++; $display("FAIL bp_hold cycle %0d got %0b exp 0", i, wr); end
      end
      checks++; if (r0 !== 1'b0 || r1 !== 1'b0 || cnt !== 16'd0) begin
         errors++; $display("FAIL bp_kept got ready %0b%0b count %0d exp 00 0", r0, r1, cnt);
      end
      full = 1'b0;
      tick();
      checks++; if (wr !== 1'b1 || wd !== 8'h11) begin errors++; $display("FAIL bp_first got %0b/%h exp 1/11", wr, wd); end
      tick();
      tick();
      checks++; if (wr !== 1'b1 || wd !== 8'h22) begin errors++; $display("FAIL bp_second got %0b/%h exp 1/22", wr, wd); end
      checks++; if (cnt !== 16'd2) begin errors++; $display("FAIL bp_count got %0d exp 2", cnt); end
   endtask

   task automatic test_fairness();
      int  k0;
      int  k1;
      int  n;
      bit  acc0;
      bit  acc1;
      int  cyc;
      do_reset();
      k0 = 0; k1 = 0; n = 0; cyc = 0;
      // Requester 0 supplies even bytes, requester 1 odd bytes; alternation yields 0x00..0x13
      while (n < 20 && cyc < 200) begin
         v0 = (k0 < 10); d0 = 8'(2 * k0);
         v1 = (k1 < 10); d1 = 8'(2 * k1 + 1);
         acc0 = v0 && r0;
         acc1 = v1 && r1;
         tick();
         cyc++;
         if (acc0) k0++;
         if (acc1) k1++;
         if (wr === 1'b1) begin
            checks++; if (wd !== 8'(n)) begin errors++; $display("FAIL fair_data write %0d got %h exp %h", n, wd, 8'(n)); end
            n++;
            checks++; if (cnt !== 16'(n)) begin errors++; $display("FAIL fair_count got %0d exp %0d", cnt, n); end
            checks++; if (s_cnt !== 3'(n)) begin errors++; $display("FAIL fair_wrap got %0d exp %0d", s_cnt, 3'(n)); end
         end
      end
      v0 = 1'b0; v1 = 1'b0;
      checks++; if (n !== 20) begin errors++; $display("FAIL fair_timeout got %0d writes exp 20", n); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (wr !== 1'b0) begin errors++; $display("FAIL fair_extra cycle %0d got %0b exp 0", i, wr); end
      end
      checks++; if (cnt !== 16'd20 || s_cnt !== 3'd4) begin errors++; $display("FAIL fair_final got %0d/%0d exp 20/4", cnt, s_cnt); end
   endtask

   task automatic test_reset_midop();
      do_reset();
      v0 = 1'b1; d0 = 8'hAA; v1 = 1'b1; d1 = 8'h55;
      tick();
      v0 = 1'b0; v1 = 1'b0;
      tick();
      checks++; if (wr !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL mid_pre got write %0b ready1 %0b exp 1 0", wr, r1); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (wr !== 1'b0) begin errors++; $display("FAIL mid_write got %0b exp 0", wr); end
      checks++; if (r0 !== 1'b1 || r1 !== 1'b1) begin errors++; $display("FAIL mid_ready got %0b%0b exp 11", r0, r1); end
      checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", cnt); end
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++; if (wr !== 1'b0) begin errors++; $display("FAIL mid_stale cycle %0d got %0b exp 0", i, wr); end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00; full = 1'b0;
      test_reset();
      test_single();
      test_tie();
      test_backpressure();
      test_fairness();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
